// File: rtl/alu_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sched_pkg
//  Description : Shared types and constants for the round-robin ALU
//                scheduler: FSM state encoding and the 3-bit ALU select
//                codes driven onto alu_sel.
//  Contents    : state_t  - IDLE / EXEC / RESP
//                OP_0..OP_7 - ALU select encodings
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // ALU select codes; the scheduler forwards these untouched, the ALU
  // decides what each one means.
  localparam logic [2:0] OP_0 = 3'd0;
  localparam logic [2:0] OP_1 = 3'd1;
  localparam logic [2:0] OP_2 = 3'd2;
  localparam logic [2:0] OP_3 = 3'd3;
  localparam logic [2:0] OP_4 = 3'd4;
  localparam logic [2:0] OP_5 = 3'd5;
  localparam logic [2:0] OP_6 = 3'd6;
  localparam logic [2:0] OP_7 = 3'd7;

endpackage : alu_sched_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Picks the first set
//                request bit at or after ptr, wrapping around.
//  Ports       : req     [NUM_REQ-1:0]  in   request levels
//                ptr     [ID_WIDTH-1:0] in   highest-priority index
//                gnt_vec [NUM_REQ-1:0]  out  one-hot winner (0 if none)
//                gnt_id  [ID_WIDTH-1:0] out  binary winner index
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt_vec,
  output logic [ID_WIDTH-1:0] gnt_id
);

  logic                w_found;
  logic [ID_WIDTH-1:0] w_idx;

  // NUM_REQ is a power of two, so the ID_WIDTH-bit add wraps the search
  // index naturally without an explicit modulo.
  always_comb begin
    gnt_vec = '0;
    gnt_id  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = ptr + ID_WIDTH'(i);
      if (!w_found && req[w_idx]) begin
        gnt_vec[w_idx] = 1'b1;
        gnt_id         = w_idx;
        w_found        = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rr_sched
//  Description : Shares one combinational ALU among NUM_REQ requesters.
//                A granted requester's operands/opcode are registered onto
//                the ALU inputs, the result is captured one cycle later and
//                returned with the requester ID on a valid/ready port.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                req/req_a/req_b/req_op   packed per-requester inputs
//                gnt               one-hot accept pulse
//                alu_a/alu_b/alu_sel      registered ALU inputs
//                alu_result        combinational ALU output
//                rsp_valid/rsp_ready/rsp_id/rsp_data  response port
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter  int DATA_WIDTH = 4,
  parameter  int NUM_REQ    = 4,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]    req_op,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [2:0]              alu_sel,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_WIDTH-1:0]     rsp_id,
  output logic [DATA_WIDTH-1:0]   rsp_data
);

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [ID_WIDTH-1:0]   r_cur_id;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [2:0]            r_alu_sel;
  logic                  r_rsp_valid;
  logic [ID_WIDTH-1:0]   r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  // --------------------------------------------------------------------------
  // Unpack the flat operand buses so the winner can be selected by index
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_a_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_b_arr  [NUM_REQ];
  logic [2:0]            w_op_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a_arr[gi]  = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_b_arr[gi]  = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_op_arr[gi] = req_op[gi*3 +: 3];
  end

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0]  w_gnt_vec;
  logic [ID_WIDTH-1:0] w_gnt_id;
  logic                w_slot_open;
  logic                w_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req),
    .ptr     (r_ptr),
    .gnt_vec (w_gnt_vec),
    .gnt_id  (w_gnt_id)
  );

  // A new operation may start when the pipe is empty, or when the pending
  // response is being consumed this very cycle (back-to-back issue).
  assign w_slot_open = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);

  // Reset gates the grant so no requester sees an accept that the
  // registers are about to discard.
  assign w_fire = w_slot_open && (|req) && !rst;
  assign gnt    = w_fire ? w_gnt_vec : '0;

  // --------------------------------------------------------------------------
  // FSM with operand and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cur_id    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      // Operand capture is shared by the IDLE and RESP issue paths.
      if (w_fire) begin
        r_alu_a   <= w_a_arr[w_gnt_id];
        r_alu_b   <= w_b_arr[w_gnt_id];
        r_alu_sel <= w_op_arr[w_gnt_id];
        r_cur_id  <= w_gnt_id;
        r_ptr     <= w_gnt_id + ID_WIDTH'(1);
      end

      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_data  <= alu_result;
          r_rsp_id    <= r_cur_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_fire ? EXEC : IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

  // --------------------------------------------------------------------------
  // Interface properties
  // --------------------------------------------------------------------------
  a_gnt_onehot : assert property (@(posedge clk) $onehot0(gnt));

  a_gnt_window : assert property (@(posedge clk)
    (gnt != '0) |-> ((r_state == IDLE) || ((r_state == RESP) && rsp_ready)));

  a_rsp_hold : assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));

endmodule : alu_rr_sched
`default_nettype wire
